fetch_stage: RTL

Instruction fetch stage that owns the program counter, drives the byte address into the combinational instruction memory, and registers the returned 32-bit word with its PC for the decode stage. Hand-off to decode uses a valid/ready handshake. The stage accepts redirects from the branch/jump logic, and raises a sticky fault on misaligned or out-of-range fetches. It sits between the execute-stage redirect path and the instruction memory/decode boundary.

---
 rtl/fetch_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory,
// and hands {pc, word} to decode over valid/ready. Bad fetches/redirects halt it until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 80
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ins,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        can_load;

  function automatic logic in_range(input logic [31:0] addr);
    return addr <= LAST_PC;
  endfunction

  function automatic logic aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_ins_d   = out_ins_q;
    fault_pc_d  = fault_pc_q;
    unique case (state_q)
      // Halted: only drain the held word; redirects are ignored and nothing new is fetched.
      ST_HALT: begin
        if (can_load) out_valid_d = 1'b0;
      end
      default: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (!aligned(redirect_pc) || !in_range(redirect_pc)) begin
            state_d    = ST_HALT;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (can_load) begin
          if (!in_range(pc_q)) begin
            state_d     = ST_HALT;
            fault_pc_d  = pc_q;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_ins_d   = imem_data;
            pc_d        = pc_q + 32'd4;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'd0;
      out_ins_q   <= 32'd0;
      fault_pc_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_ins_q   <= out_ins_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_ins   = out_ins_q;
  assign fault     = (state_q == ST_HALT);
  assign fault_pc  = fault_pc_q;

endmodule
